// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-to-parallel word assembler with a registered valid/ready output.
// Latency: a word is visible on dout the cycle after the edge that samples its last bit.
// Backpressure: a word completing while the previous one is unaccepted is dropped and sets overrun.
module sipo_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic             take_bit;
    logic             complete;
    logic             accept;
    logic             load;
    logic             drop;

    assign word     = {sr[WIDTH-2:0], sin};
    assign take_bit = bit_en & ((state == SHIFT) | start);
    assign complete = bit_en & (state == SHIFT) & (cnt == LAST);
    assign accept   = dout_valid & dout_ready;
    // An accept in the completion cycle frees the register for the new word.
    assign load     = complete & (~dout_valid | dout_ready);
    assign drop     = complete & dout_valid & ~dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bit_en && start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (complete) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    // Completion outranks start, so a start on the last bit is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (take_bit) begin
            sr <= word;
            if (complete) begin
                cnt <= '0;
            end else if (start) begin
                cnt <= CW'(1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= word;
            dout_valid <= 1'b1;
        end else if (accept) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-to-parallel deserializer that sits directly downstream of the `piso` shift-register stage. It consumes the single-bit `q` stream, MSB first, and reassembles WIDTH-bit words. Completed words are presented on a registered valid/ready output port. A sticky overrun flag is raised when a new word completes while the previous word is still unaccepted.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sin`  input  1  serial data in; connects to upstream `piso.q`.
- `bit_en`  input  1  bit strobe; `sin` and `start` are sampled only when `bit_en`=1.
- `start`  input  1  marks `sin` as the MSB (bit WIDTH-1) of a new word; qualified by `bit_en`.
- `dout`  output  WIDTH  assembled word; stable while `dout_valid`=1.
- `dout_valid`  output  1  `dout` holds an unaccepted word.
- `dout_ready`  input  1  consumer accepts `dout` when `dout_valid` & `dout_ready`.
- `busy`  output  1  a frame is partially received (state SHIFT).
- `overrun`  output  1  sticky: a completed word was dropped.
- `ovr_clr`  input  1  clears `overrun`.

## Operation
- Internal shift register `sr[WIDTH-1:0]` and bit counter `cnt` of width clog2(WIDTH).
- States:
  - IDLE: waits for `bit_en & start`; then `sr <= {sr[WIDTH-2:0], sin}`, `cnt <= 1`, goes to SHIFT.
  - SHIFT: on each `bit_en`, shifts `sin` into `sr` LSB-ward and increments `cnt`.
  - Word completion: when `bit_en` arrives with `cnt == WIDTH-1`, the word `{sr[WIDTH-2:0], sin}` is complete and the state returns to IDLE.
- `bit_en`=0 in SHIFT: state, `sr` and `cnt` hold. No timeout applies.
- `start` during SHIFT, with `bit_en`=1: aborts the partial frame without flagging. That bit is taken as the MSB of a new frame and `cnt` is set to 1.
- `start` coincident with word completion (`cnt == WIDTH-1`): the cycle counts as the last bit of the current frame and `start` is ignored.
- Output register handling of a completed word:
  - If `dout_valid`=0, or `dout_valid & dout_ready` in the same cycle: the word loads into `dout` and `dout_valid` becomes or stays 1.
  - Otherwise the word is dropped, `dout` is unchanged, and `overrun` is set to 1.
- Acceptance (`dout_valid & dout_ready`) with no word completing clears `dout_valid`.
- `overrun` holds 1 until `ovr_clr`=1. If set and clear occur in the same cycle, set wins.
- `busy` = (state == SHIFT).

## Timing
- Reset (`rst`=1 at a clock edge): state IDLE, `sr`=0, `cnt`=0, `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0.
- Reset mid-frame discards the partial word and any pending output word. Reset has priority over all inputs.
- Latency: the WIDTH-th bit is sampled at edge N; `dout`/`dout_valid` update at edge N. They are visible in the cycle after edge N.
- Continuous `bit_en`=1: a word is produced every WIDTH cycles. Back-to-back frames (`start` in the cycle after completion) incur no gap.
- `busy` rises at the edge sampling the start bit and falls at the completion edge.
- All outputs are registered. There is no combinational path from input to output.
- `dout_ready` may be held high permanently; `dout_valid` then pulses for one cycle per word.

## Test plan
- Basic word: WIDTH=4, `bit_en`=1, `start` with `sin`=1 followed by `sin` 0,1,0 on consecutive cycles. Required: `dout`=4'b1010 and `dout_valid`=1 after the 4th edge; `busy` high for 3 cycles.
- Strobe gaps: same frame as the basic word, with `bit_en`=0 for 2 cycles between bits 2 and 3. Required: `dout`=4'b1010, `dout_valid` delayed by exactly 2 cycles, `sr` unchanged during the gaps.
- Back-to-back and overrun: `dout_ready`=0, send 1101 then 0110 back-to-back. Required: `dout` stays 4'b1101 and `overrun`=1 after the 2nd frame. Then `ovr_clr`=1 clears `overrun`; then `dout_ready`=1 drops `dout_valid` one cycle later.
- Simultaneous accept and complete: `dout_valid`=1 with 4'b1101 and `dout_ready`=1 in the cycle 0110 completes. Required: `dout`=4'b0110, `dout_valid` stays 1, `overrun`=0.
- Restart: send start plus 2 bits of 1010, then `start` with 1,1,1,1. Required: `dout`=4'b1111, `overrun`=0, and only one `dout_valid` rise.
- Reset mid-frame: `rst`=1 for 1 cycle after 2 bits of a frame, with a pending word on the output. Required: next cycle `busy`=0, `dout_valid`=0, `dout`=0. A following clean frame 0011 yields `dout`=4'b0011.
